// File: rtl/q_sys_descriptor_memory_dual.sv
// Dual Avalon-MM port descriptor RAM: two slaves share one single-port array via a round-robin arbiter.
// Latency: read data returns READ_LATENCY run-cycles after grant; writes complete on the grant edge.
// Backpressure: a port's waitrequest is high while it requests without a grant; clken/reset_req stall everything.
module q_sys_descriptor_memory_dual #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 2048,
    parameter int    ADDR_WIDTH   = 11,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "q_sys_descriptor_memory_dual.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    // Power-up contents come from the device image built from INIT_FILE, not from logic here.
    if (INIT_FILE != "") begin : g_init_file
    end

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_run;
    logic                  w_req1;
    logic                  w_req2;
    logic                  w_gnt1;
    logic                  w_gnt2;
    logic                  w_gnt;
    logic                  r_last_gnt;   // 1 = s2 was granted last
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_dat;

    assign w_run  = clken & ~reset_req;
    assign w_req1 = s1_read | s1_write;
    assign w_req2 = s2_read | s2_write;
    assign w_gnt1 = w_run & w_req1 & (~w_req2 | r_last_gnt);
    assign w_gnt2 = w_run & w_req2 & (~w_req1 | ~r_last_gnt);
    assign w_gnt  = w_gnt1 | w_gnt2;

    assign s1_waitrequest = w_req1 & ~w_gnt1;
    assign s2_waitrequest = w_req2 & ~w_gnt2;

    always_comb begin
        w_addr = s1_address;
        w_be   = s1_byteenable;
        w_wdat = s1_writedata;
        w_wr   = w_gnt1 & s1_write;
        if (w_gnt2) begin
            w_addr = s2_address;
            w_be   = s2_byteenable;
            w_wdat = s2_writedata;
            w_wr   = s2_write;
        end
    end

    // A granted port is requesting, so anything that is not a write is a read.
    assign w_rd       = w_gnt & ~w_wr;
    assign w_in_range = {1'b0, w_addr} < DEPTH_L;
    assign w_idx      = w_addr[IDX_W-1:0];
    assign w_rd_dat   = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset_n && w_wr && w_in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt) begin
            r_last_gnt <= w_gnt2;
        end
    end

    logic                  w_beat_vld;
    logic                  w_beat_port;
    logic [DATA_WIDTH-1:0] w_beat_dat;

    if (READ_LATENCY >= 2) begin : g_lat2
        logic                  r_mid_vld;
        logic                  r_mid_port;
        logic [DATA_WIDTH-1:0] r_mid_dat;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_mid_vld  <= 1'b0;
                r_mid_port <= 1'b0;
                r_mid_dat  <= '0;
            end else if (w_run) begin
                r_mid_vld  <= w_rd;
                r_mid_port <= w_gnt2;
                r_mid_dat  <= w_rd_dat;
            end
        end

        assign w_beat_vld  = r_mid_vld;
        assign w_beat_port = r_mid_port;
        assign w_beat_dat  = r_mid_dat;
    end else begin : g_lat1
        assign w_beat_vld  = w_rd;
        assign w_beat_port = w_gnt2;
        assign w_beat_dat  = w_rd_dat;
    end

    logic                  r_s1_vld;
    logic                  r_s2_vld;
    logic [DATA_WIDTH-1:0] r_s1_dat;
    logic [DATA_WIDTH-1:0] r_s2_dat;

    // Per-port output registers; a stalled beat stays parked here until run returns.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s2_dat <= '0;
        end else if (w_run) begin
            r_s1_vld <= w_beat_vld & ~w_beat_port;
            r_s2_vld <= w_beat_vld & w_beat_port;
            if (w_beat_vld && !w_beat_port) begin
                r_s1_dat <= w_beat_dat;
            end
            if (w_beat_vld && w_beat_port) begin
                r_s2_dat <= w_beat_dat;
            end
        end
    end

    assign s1_readdata      = r_s1_dat;
    assign s2_readdata      = r_s2_dat;
    assign s1_readdatavalid = r_s1_vld & w_run & reset_n;
    assign s2_readdatavalid = r_s2_vld & w_run & reset_n;

endmodule
